// File: rtl/iter_div_16bit_pkg.sv
// ============================================================================
// iter_div_16bit_pkg : shared state encoding and default width for the divider
// Revision 1.0
// ============================================================================
`default_nettype none

package iter_div_16bit_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/iter_div_16bit_trial_sub.sv
// ============================================================================
// iter_div_16bit_trial_sub : a - b via a + ~b + 1 over 4-bit CLA slices
// Revision 1.0
// ============================================================================
`default_nettype none

module iter_div_16bit_trial_sub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         no_borrow_o
);

  localparam int NS = (W + 3) / 4;
  localparam int EW = NS * 4;

  // Zero-extension to a whole slice keeps the carry out equal to (a >= b).
  logic [EW-1:0] w_a;
  logic [EW-1:0] w_b;
  logic [NS:0]   w_carry;

  assign w_a        = EW'(a_i);
  assign w_b        = ~EW'(b_i);
  assign w_carry[0] = 1'b1;
  assign no_borrow_o = w_carry[NS];

  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p    = w_a[4*s +: 4] ^ w_b[4*s +: 4];
    assign w_g    = w_a[4*s +: 4] & w_b[4*s +: 4];
    assign w_c[0] = w_carry[s];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_carry[s+1] = w_c[4];

    for (genvar j = 0; j < 4; j++) begin : g_bit
      if (4*s + j < W) begin : g_sum
        assign diff_o[4*s + j] = w_p[j] ^ w_c[j];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iter_div_16bit.sv
// ============================================================================
// iter_div_16bit : multi-cycle unsigned restoring divider (quotient/remainder)
// Revision 1.0
// ============================================================================
`default_nettype none

module iter_div_16bit
  import iter_div_16bit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             zpend_q, zpend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_no_borrow;

  // rem is always below the divisor, so its top bit drops out of the shift.
  assign w_shift = (WIDTH+1)'({rem_q, q_q[WIDTH-1]});

  iter_div_16bit_trial_sub #(
    .W (WIDTH + 1)
  ) u_trial_sub (
    .a_i         (w_shift),
    .b_i         ({1'b0, dvsr_q}),
    .diff_o      (w_diff),
    .no_borrow_o (w_no_borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    zpend_d = zpend_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          dbz_d  = 1'b0;
          dvsr_d = divisor;
          if (divisor != '0) begin
            rem_d   = '0;
            q_d     = dividend;
            cnt_d   = CW'(WIDTH - 1);
            zpend_d = 1'b0;
            state_d = S_CALC;
          end else begin
            rem_d   = {1'b0, dividend};
            q_d     = '1;
            zpend_d = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_CALC: begin
        rem_d = w_no_borrow ? w_diff : w_shift;
        q_d   = {q_q[WIDTH-2:0], w_no_borrow};
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIN: begin
        quot_d  = q_q;
        remo_d  = rem_q[WIDTH-1:0];
        dbz_d   = zpend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      zpend_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      zpend_q <= zpend_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_div_16bit.sv
// ============================================================================
// tb_iter_div_16bit : directed and random checks against an arithmetic model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_iter_div_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  iter_div_16bit #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_div(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] q, output logic [15:0] r, output logic z);
    if (b == 16'd0) begin
      q = 16'hFFFF; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic check_result(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] eq, er;
    logic        ez;
    ref_div(a, b, eq, er, ez);
    check_val("quotient",  32'(quotient),    32'(eq));
    check_val("remainder", 32'(remainder),   32'(er));
    check_val("dbz",       32'(div_by_zero), 32'(ez));
    if (b != 16'd0) begin
      check_val("invariant", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check_val("rem_lt_div", 32'(remainder < b), 32'd1);
    end
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_start", 32'(busy), 32'd1);
    check_val("dbz_cleared", 32'(div_by_zero), 32'd0);
  endtask

  task automatic do_div(input logic [15:0] a, input logic [15:0] b);
    int e;
    launch(a, b);
    wait_done(e);
    check_val("done_seen", 32'(done), 32'd1);
    check_val("latency", 32'(e), (b == 16'd0) ? 32'd1 : 32'd17);
    check_result(a, b);
    @(posedge clk); #1;
    check_val("done_width", 32'(done), 32'd0);
  endtask

  initial begin
    int e;
    int seen;
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_quot", 32'(quotient), 32'd0);
    check_val("rst_rem",  32'(remainder), 32'd0);
    check_val("rst_dbz",  32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div(16'd100, 16'd7);
    do_div(16'hFFFF, 16'd1);
    do_div(16'd5, 16'hFFFF);
    do_div(16'd1234, 16'd0);

    // Start pulse mid-operation must be ignored.
    launch(16'd1000, 16'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 16'd777; divisor = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(e);
    check_val("ign_done_seen", 32'(done), 32'd1);
    check_result(16'd1000, 16'd3);

    // Start held through the done cycle: ignored there, accepted on the next edge.
    dividend = 16'd50000; divisor = 16'd123; start = 1'b1;
    @(posedge clk); #1;
    check_val("start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("b2b_accept", 32'(busy), 32'd1);
    wait_done(e);
    check_val("b2b_latency", 32'(e), 32'd17);
    check_result(16'd50000, 16'd123);
    @(posedge clk); #1;

    // Reset in the middle of an operation.
    launch(16'd40000, 16'd7);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_done", 32'(done), 32'd0);
    check_val("mid_rst_quot", 32'(quotient), 32'd0);
    check_val("mid_rst_rem",  32'(remainder), 32'd0);
    check_val("mid_rst_dbz",  32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check_val("no_done_after_rst", 32'(seen), 32'd0);
    do_div(16'd40000, 16'd7);

    for (int i = 0; i < 2000; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = 16'hFFFF - 16'($urandom_range(0, 3));
        3:       rb = ra;
        default: rb = 16'($urandom);
      endcase
      do_div(ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
